// File: rtl/unpack_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping at N-1.
// Uses a doubled request vector so the wrap needs no separate second scan.
module rr_pick #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_vld,
    output logic [SW-1:0] gnt_idx
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] rot;
    logic [SW:0]    sum;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        dbl     = {req, req};
        rot     = dbl >> ptr;
        // Scanning downward lets the closest request to ptr win by being assigned last.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_vld = 1'b1;
                sum     = {1'b0, ptr} + (SW + 1)'(k);
                if (sum >= (SW + 1)'(N)) begin
                    sum = sum - (SW + 1)'(N);
                end
                gnt_idx = sum[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/unpack_arbiter.sv
// Shares one W-bit beat stream between N requesters of D-beat words, round-robin,
// holding each grant until all beats of the accepted word have left.
module unpack_arbiter #(
    parameter  int W  = 8,
    parameter  int D  = 2,
    parameter  int N  = 4,
    localparam int SW = $clog2(N),
    localparam int IW = $clog2(D)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     s_stb,
    input  logic [N*W*D-1:0] s_dat,
    output logic [N-1:0]     s_rdy,
    input  logic             m_rdy,
    output logic             m_stb,
    output logic [W-1:0]     m_dat,
    output logic [SW-1:0]    m_src,
    output logic             m_last
);

    localparam int   WW   = W * D;
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic          state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WW-1:0] word_q, word_in;
    logic          load;
    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;
    logic          last_beat;
    logic          m_stb_d, m_last_d;
    logic [W-1:0]  m_dat_d;
    logic [SW-1:0] m_src_d;

    rr_pick #(.N(N)) u_pick (
        .req     (s_stb),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign word_in   = s_dat[int'(gnt_idx) * WW +: WW];
    assign last_beat = (idx_q == IW'(D - 1));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        m_stb_d  = m_stb;
        m_dat_d  = m_dat;
        m_src_d  = m_src;
        m_last_d = m_last;
        load     = 1'b0;
        s_rdy    = '0;

        if (state_q == IDLE) begin
            if (gnt_vld) begin
                for (int i = 0; i < N; i++) begin
                    s_rdy[i] = (gnt_idx == SW'(i));
                end
                load     = 1'b1;
                ptr_d    = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
                m_src_d  = gnt_idx;
                m_dat_d  = word_in[W-1:0];
                m_stb_d  = 1'b1;
                m_last_d = 1'b0;
                idx_d    = '0;
                state_d  = BUSY;
            end
        end else if (m_rdy) begin
            if (last_beat) begin
                m_stb_d  = 1'b0;
                m_last_d = 1'b0;
                state_d  = IDLE;
            end else begin
                idx_d    = idx_q + 1'b1;
                m_dat_d  = W'(word_q >> ((int'(idx_q) + 1) * W));
                m_last_d = (int'(idx_q) + 2 == D);
            end
        end

        if (rst) begin
            s_rdy = '0;
            load  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            m_stb   <= 1'b0;
            m_dat   <= '0;
            m_src   <= '0;
            m_last  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            m_stb   <= m_stb_d;
            m_dat   <= m_dat_d;
            m_src   <= m_src_d;
            m_last  <= m_last_d;
        end
    end

    // NOTE: the word buffer carries no reset; it is only read after a grant has loaded it.
    always_ff @(posedge clk) begin
        if (load) begin
            word_q <= word_in;
        end
    end

endmodule

// File: tb/tb_unpack_arbiter.sv
// Self-checking bench: two arbiter instances (N=4/D=2 and N=3/D=4) against a
// beat-queue reference model, plus directed cases with hand-computed values.
module tb_unpack_arbiter;

    localparam int W  = 8;
    localparam int NA = 4;
    localparam int DA = 2;
    localparam int NB = 3;
    localparam int DB = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                m_rdy = 1'b1;

    logic [NA-1:0]       s_stb_a = '0;
    logic [NA*W*DA-1:0]  s_dat_a = '0;
    logic [NA-1:0]       s_rdy_a;
    logic                m_stb_a;
    logic [W-1:0]        m_dat_a;
    logic [1:0]          m_src_a;
    logic                m_last_a;

    logic [NB-1:0]       s_stb_b = '0;
    logic [NB*W*DB-1:0]  s_dat_b = '0;
    logic [NB-1:0]       s_rdy_b;
    logic                m_stb_b;
    logic [W-1:0]        m_dat_b;
    logic [1:0]          m_src_b;
    logic                m_last_b;

    always #5 clk = ~clk;

    unpack_arbiter #(.W(W), .D(DA), .N(NA)) dut_a (
        .clk (clk), .rst (rst),
        .s_stb (s_stb_a), .s_dat (s_dat_a), .s_rdy (s_rdy_a),
        .m_rdy (m_rdy), .m_stb (m_stb_a), .m_dat (m_dat_a),
        .m_src (m_src_a), .m_last (m_last_a)
    );

    unpack_arbiter #(.W(W), .D(DB), .N(NB)) dut_b (
        .clk (clk), .rst (rst),
        .s_stb (s_stb_b), .s_dat (s_dat_b), .s_rdy (s_rdy_b),
        .m_rdy (m_rdy), .m_stb (m_stb_b), .m_dat (m_dat_b),
        .m_src (m_src_b), .m_last (m_last_b)
    );

    // Model: a queue of pending beats per arbiter plus the round-robin pointer.
    typedef struct {
        bit         busy;
        int         ptr;
        logic [7:0] beats[4];
        int         head;
        int         cnt;
        bit         stb;
        logic [7:0] dat;
        int         src;
        bit         last;
    } mdl_t;

    mdl_t ma, mb;
    int   checks   = 0;
    int   failures = 0;
    bit   armed    = 1'b0;
    int   gq[$];
    int   gc[$];
    int   exp_a[5] = '{0, 1, 2, 3, 0};
    int   exp_b[4] = '{0, 1, 2, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input mdl_t m, input int n, input logic [3:0] stb);
        if (m.busy) return -1;
        for (int k = 0; k < n; k++) begin
            if (stb[(m.ptr + k) % n]) return (m.ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(input mdl_t m, input int n, input logic [3:0] stb, input bit r);
        int g;
        g = pick(m, n, stb);
        if (r || g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int n, input int d, input logic [3:0] stb,
                                  input logic [31:0] w[4], input bit mrdy, input bit r);
        mdl_t o;
        int   g;
        o = m;
        if (r) begin
            o.busy = 0; o.ptr = 0; o.head = 0; o.cnt = 0;
            o.stb = 0; o.dat = 8'h00; o.src = 0; o.last = 0;
            return o;
        end
        if (!m.busy) begin
            g = pick(m, n, stb);
            if (g >= 0) begin
                for (int k = 0; k < d; k++) o.beats[k] = w[g][k*8 +: 8];
                o.head = 0;
                o.cnt  = d;
                o.dat  = o.beats[0];
                o.src  = g;
                o.stb  = 1;
                o.last = (d == 1);
                o.ptr  = (g + 1) % n;
                o.busy = 1;
            end
        end else if (mrdy) begin
            o.head++;
            o.cnt--;
            if (o.cnt == 0) begin
                o.busy = 0;
                o.stb  = 0;
                o.last = 0;
            end else begin
                o.dat  = o.beats[o.head];
                o.last = (o.cnt == 1);
            end
        end
        return o;
    endfunction

    // Compare process: registered outputs at the falling edge, s_rdy and model step mid-low-phase.
    initial begin
        logic [31:0] wa[4];
        logic [31:0] wb[4];
        forever begin
            @(negedge clk);
            if (armed) begin
                check("a_m_stb",  m_stb_a,  ma.stb);
                check("a_m_dat",  m_dat_a,  ma.dat);
                check("a_m_src",  m_src_a,  ma.src);
                check("a_m_last", m_last_a, ma.last);
                check("b_m_stb",  m_stb_b,  mb.stb);
                check("b_m_dat",  m_dat_b,  mb.dat);
                check("b_m_src",  m_src_b,  mb.src);
                check("b_m_last", m_last_b, mb.last);
            end
            #3;
            if (armed || rst) begin
                check("a_s_rdy", s_rdy_a, exp_rdy(ma, NA, s_stb_a, rst));
                check("b_s_rdy", {1'b0, s_rdy_b}, exp_rdy(mb, NB, {1'b0, s_stb_b}, rst));
            end
            for (int i = 0; i < 4; i++) begin
                wa[i] = {16'h0000, s_dat_a[i*16 +: 16]};
                wb[i] = (i < NB) ? s_dat_b[i*32 +: 32] : 32'h0;
            end
            ma = step(ma, NA, DA, s_stb_a, wa, m_rdy, rst);
            mb = step(mb, NB, DB, {1'b0, s_stb_b}, wb, m_rdy, rst);
            if (rst) armed = 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic grant_one(input logic [3:0] stb, input logic [3:0] exp, input string name);
        s_stb_a = stb;
        s_dat_a = {$urandom(), $urandom()};
        #1;
        check(name, s_rdy_a, exp);
        tick();
        s_stb_a = '0;
        tick();
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_m_stb_a",  m_stb_a,  1'b0);
        check("rst_m_dat_a",  m_dat_a,  8'h00);
        check("rst_m_src_a",  m_src_a,  2'd0);
        check("rst_m_last_a", m_last_a, 1'b0);
        check("rst_m_stb_b",  m_stb_b,  1'b0);

        // Single request from requester 2, word 0xBEEF.
        tick();
        s_stb_a = 4'b0100;
        s_dat_a = {$urandom(), $urandom()};
        s_dat_a[32 +: 16] = 16'hBEEF;
        #1;
        check("t1_rdy", s_rdy_a, 4'b0100);
        tick();
        s_stb_a = '0;
        s_dat_a = {$urandom(), $urandom()};
        #1;
        check("t1_rdy_once", s_rdy_a, 4'b0000);
        check("t1_b0_stb",  m_stb_a,  1'b1);
        check("t1_b0_dat",  m_dat_a,  8'hEF);
        check("t1_b0_src",  m_src_a,  2'd2);
        check("t1_b0_last", m_last_a, 1'b0);
        tick();
        #1;
        check("t1_b1_stb",  m_stb_a,  1'b1);
        check("t1_b1_dat",  m_dat_a,  8'hBE);
        check("t1_b1_last", m_last_a, 1'b1);
        tick();
        #1;
        check("t1_end_stb",  m_stb_a,  1'b0);
        check("t1_end_dat",  m_dat_a,  8'hBE);
        check("t1_end_src",  m_src_a,  2'd2);
        check("t1_end_last", m_last_a, 1'b0);
        grant_one(4'b1001, 4'b1000, "t1_ptr3");

        // Round-robin fairness with all four requesting.
        s_stb_a = 4'b1111;
        for (int c = 0; c < 14; c++) begin
            s_dat_a = {$urandom(), $urandom()};
            #1;
            if (s_rdy_a != '0) begin
                for (int i = 0; i < NA; i++) if (s_rdy_a[i]) gq.push_back(i);
                gc.push_back(c);
            end
            tick();
        end
        s_stb_a = '0;
        tick();
        check("t2_ngrants", gq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) check("t2_order", gq[i], exp_a[i]);
            if (i > 0 && i < gc.size()) check("t2_spacing", gc[i] - gc[i-1], 3);
        end

        // Backpressure: five stalled edges on beat 0 while others request.
        s_stb_a = 4'b0010;
        s_dat_a = {$urandom(), $urandom()};
        s_dat_a[16 +: 16] = 16'h1234;
        #1;
        check("t3_rdy", s_rdy_a, 4'b0010);
        tick();
        s_stb_a = 4'b1101;
        m_rdy   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t3_stall_stb",  m_stb_a,  1'b1);
            check("t3_stall_dat",  m_dat_a,  8'h34);
            check("t3_stall_last", m_last_a, 1'b0);
            check("t3_stall_rdy",  s_rdy_a,  4'b0000);
            tick();
        end
        m_rdy   = 1'b1;
        s_stb_a = '0;
        #1;
        check("t3_held_dat", m_dat_a, 8'h34);
        tick();
        #1;
        check("t3_b1_dat",  m_dat_a,  8'h12);
        check("t3_b1_last", m_last_a, 1'b1);
        tick();

        // Wrap and skip: bring ptr to 3, then 4'b0011 twice.
        grant_one(4'b0100, 4'b0100, "t4_pre");
        grant_one(4'b0011, 4'b0001, "t4_wrap");
        grant_one(4'b0011, 4'b0010, "t4_skip");

        // Non-power-of-two instance, all three requesting.
        gq.delete();
        gc.delete();
        s_stb_b = 3'b111;
        for (int c = 0; c < 17; c++) begin
            s_dat_b = {$urandom(), $urandom(), $urandom()};
            #1;
            if (s_rdy_b != '0) begin
                for (int i = 0; i < NB; i++) if (s_rdy_b[i]) gq.push_back(i);
                gc.push_back(c);
            end
            check("t6_src_range", m_src_b < 2'd3, 1'b1);
            tick();
        end
        s_stb_b = '0;
        repeat (4) tick();
        check("t6_ngrants", gq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) check("t6_order", gq[i], exp_b[i]);
            if (i > 0 && i < gc.size()) check("t6_spacing", gc[i] - gc[i-1], DB + 1);
        end

        // Reset after beat 0 of a four-beat word.
        s_stb_b = 3'b010;
        s_dat_b = {$urandom(), $urandom(), $urandom()};
        s_dat_b[32 +: 32] = 32'hA1B2C3D4;
        #1;
        check("t5_rdy", s_rdy_b, 3'b010);
        tick();
        s_stb_b = '0;
        #1;
        check("t5_b0_stb", m_stb_b, 1'b1);
        check("t5_b0_dat", m_dat_b, 8'hD4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t5_rst_stb", m_stb_b, 1'b0);
        check("t5_rst_dat", m_dat_b, 8'h00);
        check("t5_rst_src", m_src_b, 2'd0);
        tick();
        #1;
        check("t5_no_beats", m_stb_b, 1'b0);
        s_stb_b = 3'b110;
        #1;
        check("t5_scan0", s_rdy_b, 3'b010);
        tick();
        s_stb_b = '0;
        repeat (5) tick();

        // Randomized traffic, backpressure and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 249) == 0);
            s_stb_a = 4'($urandom_range(0, 15));
            s_stb_b = 3'($urandom_range(0, 7));
            s_dat_a = {$urandom(), $urandom()};
            s_dat_b = {$urandom(), $urandom(), $urandom()};
            m_rdy   = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst     = 1'b0;
        s_stb_a = '0;
        s_stb_b = '0;
        m_rdy   = 1'b1;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
